// File: rtl/dds_freq_meter.sv
// Frequency/peak meter for a signed DDS sample stream: counts valid samples over NCYC signal periods.
// Optional build macro DDS_METER_HYST_EN enables a hysteresis-based crossing detector.
module dds_freq_meter #(
    parameter int DW   = 12,
    parameter int CW   = 32,
    parameter int NCYC = 16,
    parameter int TMO  = 1048576
`ifdef DDS_METER_HYST_EN
    , parameter int HYST = 16
`endif
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic signed [DW-1:0] DIN,
    input  logic                 DIN_VLD,
    output logic                 BUSY,
    output logic [CW-1:0]        PERIOD_SUM,
    output logic signed [DW-1:0] PK_MAX,
    output logic signed [DW-1:0] PK_MIN,
    output logic                 RES_VLD,
    output logic                 TMO_ERR
);

    localparam int TW = (TMO > 1) ? $clog2(TMO + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEASURE, S_DONE} state_t;

    state_t                state_reg;
    logic [CW-1:0]         sample_cnt_reg;
    logic [7:0]            cross_cnt_reg;
    logic [TW-1:0]         tmo_cnt_reg;
    logic signed [DW-1:0]  max_trk_reg;
    logic signed [DW-1:0]  min_trk_reg;
    logic                  crossing;
    logic [CW-1:0]         sample_cnt_next;
    logic signed [DW-1:0]  max_next;
    logic signed [DW-1:0]  min_next;

`ifdef DDS_METER_HYST_EN
    localparam logic signed [DW-1:0] HYST_POS = DW'(HYST);
    localparam logic signed [DW-1:0] HYST_NEG = -HYST_POS;

    // Detector arms deep in the negative half and fires once on the first strong positive sample.
    logic armed_reg;

    assign crossing = DIN_VLD && armed_reg && (DIN >= HYST_POS);

    always_ff @(posedge CLK) begin
        if (RST) begin
            armed_reg <= 1'b0;
        end else if (DIN_VLD) begin
            if (DIN <= HYST_NEG)
                armed_reg <= 1'b1;
            else if (crossing)
                armed_reg <= 1'b0;
        end
    end
`else
    logic signed [DW-1:0] prev_reg;

    assign crossing = DIN_VLD && !DIN[DW-1] && prev_reg[DW-1];

    always_ff @(posedge CLK) begin
        if (RST)
            prev_reg <= '0;
        else if (DIN_VLD)
            prev_reg <= DIN;
    end
`endif

    assign sample_cnt_next = (&sample_cnt_reg) ? sample_cnt_reg : sample_cnt_reg + 1'b1;
    assign max_next        = (DIN > max_trk_reg) ? DIN : max_trk_reg;
    assign min_next        = (DIN < min_trk_reg) ? DIN : min_trk_reg;
    assign BUSY            = (state_reg == S_ARM) || (state_reg == S_MEASURE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= S_IDLE;
            sample_cnt_reg <= '0;
            cross_cnt_reg  <= '0;
            tmo_cnt_reg    <= '0;
            max_trk_reg    <= '0;
            min_trk_reg    <= '0;
            PERIOD_SUM     <= '0;
            PK_MAX         <= '0;
            PK_MIN         <= '0;
            RES_VLD        <= 1'b0;
            TMO_ERR        <= 1'b0;
        end else begin
            RES_VLD <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (START) begin
                        state_reg     <= S_ARM;
                        TMO_ERR       <= 1'b0;
                        cross_cnt_reg <= '0;
                        tmo_cnt_reg   <= '0;
                    end
                end
                S_ARM, S_MEASURE: begin
                    if (crossing && state_reg == S_ARM) begin
                        state_reg      <= S_MEASURE;
                        sample_cnt_reg <= '0;
                        cross_cnt_reg  <= '0;
                        tmo_cnt_reg    <= '0;
                        max_trk_reg    <= DIN;
                        min_trk_reg    <= DIN;
                    end else if (crossing && cross_cnt_reg == 8'(NCYC - 1)) begin
                        // Final crossing sample is folded straight into the published result.
                        state_reg  <= S_DONE;
                        PERIOD_SUM <= sample_cnt_next;
                        PK_MAX     <= max_next;
                        PK_MIN     <= min_next;
                        RES_VLD    <= 1'b1;
                    end else begin
                        if (state_reg == S_MEASURE && DIN_VLD) begin
                            sample_cnt_reg <= sample_cnt_next;
                            max_trk_reg    <= max_next;
                            min_trk_reg    <= min_next;
                            if (crossing)
                                cross_cnt_reg <= cross_cnt_reg + 8'd1;
                        end
                        if (crossing) begin
                            tmo_cnt_reg <= '0;
                        end else if (tmo_cnt_reg == TW'(TMO - 1)) begin
                            TMO_ERR   <= 1'b1;
                            state_reg <= S_IDLE;
                        end else begin
                            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dds_freq_meter.md
DDS_FREQ_METER -- requirements
Module: dds_freq_meter

Interface
REQ-001 Parameter DW, default 12: width of the signed two's-complement sample.
REQ-002 Parameter CW, default 32: width of the period accumulator.
REQ-003 Parameter NCYC, default 16: number of signal periods per measurement gate, range 1..255.
REQ-004 Parameter TMO, default 1048576: timeout in clock cycles without a rising crossing.
REQ-005 Parameter HYST, default 16: hysteresis threshold magnitude; used only when DDS_METER_HYST_EN is defined.
REQ-006 CLK  input  1  system clock; all logic on rising edge; one clock domain.
REQ-007 RST  input  1  synchronous, active-high reset.
REQ-008 START  input  1  one-cycle request to begin a measurement.
REQ-009 DIN  input  DW  signed sample from the DDS output.
REQ-010 DIN_VLD  input  1  DIN qualifier; samples with DIN_VLD=0 are ignored.
REQ-011 BUSY  output  1  high in ARM or MEASURE.
REQ-012 PERIOD_SUM  output  CW  valid samples spanning NCYC periods.
REQ-013 PK_MAX  output  DW  largest sample seen during MEASURE.
REQ-014 PK_MIN  output  DW  smallest sample seen during MEASURE.
REQ-015 RES_VLD  output  1  one-cycle pulse; result outputs updated.
REQ-016 TMO_ERR  output  1  sticky timeout flag.

Function
REQ-017 States: IDLE, ARM, MEASURE, DONE. START in IDLE -> ARM; START in any other state is ignored.
REQ-018 Rising crossing: a valid sample >= 0 whose previous valid sample was < 0. The previous-sample register resets to 0.
REQ-019 Entering ARM clears TMO_ERR, the crossing count and the timeout counter.
REQ-020 ARM -> MEASURE on the first rising crossing. On that crossing:
  - sample counter := 0
  - crossing count := 0
  - PK_MAX/PK_MIN trackers := that sample
REQ-021 In MEASURE, each valid sample does all of the following:
  - increments the sample counter, saturating at all-ones
  - updates the peak trackers
  - on a rising crossing, increments the crossing count
REQ-022 MEASURE -> DONE in the cycle the NCYC-th crossing sample is accepted; that sample is included in the count.
  - For an input of exact period P samples, PERIOD_SUM = NCYC*P.
REQ-023 DONE behaviour:
  - latches PERIOD_SUM, PK_MAX and PK_MIN
  - asserts RES_VLD for exactly one cycle, one clock after the final crossing sample
  - returns to IDLE the next cycle
  - result outputs hold until the next DONE
REQ-024 Timeout counter:
  - counts every clock in ARM/MEASURE and clears on each rising crossing
  - on reaching TMO: set TMO_ERR, go to IDLE, no RES_VLD, results unchanged
REQ-025 If a crossing and timeout expiry occur in the same cycle, the crossing wins.
REQ-026 Gaps in DIN_VLD are allowed: they advance the timeout counter only, not the sample counter or the crossing detector.

Reset
REQ-027 RST=1 forces the following, overriding any in-flight measurement and any START in the same cycle:
  - state IDLE
  - BUSY=0, RES_VLD=0, TMO_ERR=0
  - PERIOD_SUM=0, PK_MAX=0, PK_MIN=0
  - all counters 0, previous sample 0
REQ-028 After RST deasserts, no result is produced until a new START.

Configuration
REQ-029 Macro DDS_METER_HYST_EN, when defined:
  - the detector arms when a valid sample <= -HYST
  - a crossing is the first valid sample >= +HYST after arming
  - the detector disarms on that crossing
  - this replaces the REQ-018 rule
REQ-030 When DDS_METER_HYST_EN is undefined, the REQ-018 rule applies, and HYST and the arming logic are absent.

Verification
REQ-031 Square wave, 4 samples -500 then 4 samples +500, DIN_VLD=1, NCYC=16, START -> RES_VLD pulse, PERIOD_SUM=128, PK_MAX=500, PK_MIN=-500, TMO_ERR=0.
REQ-032 Same wave with DIN_VLD low every other clock -> PERIOD_SUM=128, RES_VLD one cycle only.
REQ-033 DIN held at 100, START, TMO=64 -> TMO_ERR=1 exactly 64 clocks after START accepted, BUSY=0, no RES_VLD.
REQ-034 RST asserted mid-MEASURE after 5 crossings -> next cycle all outputs 0 and state IDLE; a following START gives a correct full result.
REQ-035 With DDS_METER_HYST_EN, HYST=16, square wave of amplitude 500 with ±8 glitches around 0 -> PERIOD_SUM=128. Without the macro, the same input gives a smaller PERIOD_SUM.
REQ-036 START pulsed while BUSY=1 -> ignored; result identical to REQ-031.
